// File: rtl/serial_tx_frame_controller_pkg.sv
// Shared constants for the UART transmit frame sequencer: state codes, SCON mode codes
// and the data-bit counts per mode.
package serial_tx_frame_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5,
    ST_DONE  = 3'd6
  } tx_state_e;

  // Mode code is {SM0, SM1}.
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } tx_mode_e;

  localparam int TX_BITS_MODE01 = 8;
  localparam int TX_BITS_MODE23 = 9;
  localparam int TX_CNT_W       = 4;

endpackage

// File: rtl/serial_tx_frame_controller_bit_counter.sv
// Data-bit counter: synchronous clear, saturating increment, and a flag that marks
// the increment which reaches the limit.
module serial_tx_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != limit_i)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = ((cnt_q + ONE) == limit_i);

endmodule

// File: rtl/serial_tx_frame_controller.sv
// UART transmit frame sequencer: load, optional start bit, data shifts, optional stop
// bit and TI, all paced by an external bit-rate tick. All outputs come from flops.
module serial_tx_frame_controller
  import serial_tx_frame_controller_pkg::*;
#(
  parameter int BITS_MODE01 = TX_BITS_MODE01,
  parameter int BITS_MODE23 = TX_BITS_MODE23,
  parameter int CNT_W       = TX_CNT_W
) (
  input  logic serial_clock_i,
  input  logic serial_reset_i_b,
  input  logic serial_sbuf_write_i,
  input  logic serial_scon7_sm0_i,
  input  logic serial_scon6_sm1_i,
  input  logic serial_bit_tick_i,
  input  logic serial_end_bit_i,
  output logic serial_start_shifter_reg_o,
  output logic serial_shift_o,
  output logic serial_start_bit_o,
  output logic serial_stop_bit_gen_o,
  output logic serial_ti_set_o,
  output logic serial_tx_busy_o,
  output logic serial_tx_err_o
);

  localparam logic [CNT_W-1:0] LIMIT01 = CNT_W'(BITS_MODE01);
  localparam logic [CNT_W-1:0] LIMIT23 = CNT_W'(BITS_MODE23);

  tx_state_e  state_q, state_d;
  tx_mode_e   mode_q, mode_d;
  logic       err_q, err_d;
  logic       load_q, load_d;
  logic       shift_q, shift_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       ti_q, ti_d;
  logic       busy_q, busy_d;
  logic       chk_q, chk_d;
  logic       nth_q, nth_d;
  logic       cnt_clr, cnt_en, cnt_last;
  logic [CNT_W-1:0] cnt_limit;

  // SM0 selects the 9-bit (TB8) frames.
  assign cnt_limit = mode_q[1] ? LIMIT23 : LIMIT01;

  serial_tx_bit_counter #(.CNT_W(CNT_W)) u_bit_counter (
    .clk_i   (serial_clock_i),
    .rst_ni  (serial_reset_i_b),
    .clear_i (cnt_clr),
    .en_i    (cnt_en),
    .limit_i (cnt_limit),
    .last_o  (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    err_d   = err_q;
    load_d  = 1'b0;
    shift_d = 1'b0;
    ti_d    = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    // chk_q marks the cycle after the last shift pulse, when the shifter flag is valid.
    if (chk_q && !serial_end_bit_i) err_d = 1'b1;
    if (serial_sbuf_write_i && (state_q != ST_IDLE)) err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (serial_sbuf_write_i) begin
          state_d = ST_LOAD;
          load_d  = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      ST_LOAD: begin
        mode_d  = tx_mode_e'({serial_scon7_sm0_i, serial_scon6_sm1_i});
        state_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        if (serial_bit_tick_i) state_d = (mode_q == MODE0) ? ST_DATA : ST_START;
      end
      ST_START: begin
        if (serial_bit_tick_i) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (serial_bit_tick_i) begin
          shift_d = 1'b1;
          cnt_en  = 1'b1;
          if (cnt_last) begin
            // Registered TI lands in DONE for mode 0 and in the first STOP cycle otherwise.
            ti_d    = 1'b1;
            state_d = (mode_q == MODE0) ? ST_DONE : ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (serial_bit_tick_i) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase

    nth_d   = shift_d && cnt_last;
    chk_d   = nth_q;
    start_d = (state_d == ST_START);
    stop_d  = (state_d == ST_STOP);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge serial_clock_i) begin
    if (!serial_reset_i_b) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      shift_q <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      ti_q    <= 1'b0;
      busy_q  <= 1'b0;
      nth_q   <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      load_q  <= load_d;
      shift_q <= shift_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      ti_q    <= ti_d;
      busy_q  <= busy_d;
      nth_q   <= nth_d;
      chk_q   <= chk_d;
    end
  end

  assign serial_start_shifter_reg_o = load_q;
  assign serial_shift_o             = shift_q;
  assign serial_start_bit_o         = start_q;
  assign serial_stop_bit_gen_o      = stop_q;
  assign serial_ti_set_o            = ti_q;
  assign serial_tx_busy_o           = busy_q;
  assign serial_tx_err_o            = err_q;

endmodule

// File: tb/tb_serial_tx_frame_controller.sv
// Bench for serial_tx_frame_controller: a tick-counting frame model checked every cycle,
// a table of directed frames with frame-level expectations, then randomized traffic.
module tb_serial_tx_frame_controller;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic wr = 1'b0;
  logic sm0 = 1'b0;
  logic sm1 = 1'b0;
  logic tick = 1'b0;
  logic end_bit = 1'b0;
  logic load_o, shift_o, start_o, stop_o, ti_o, busy_o, err_o;

  always #5 clk = ~clk;

  serial_tx_frame_controller dut (
    .serial_clock_i             (clk),
    .serial_reset_i_b           (rst_b),
    .serial_sbuf_write_i        (wr),
    .serial_scon7_sm0_i         (sm0),
    .serial_scon6_sm1_i         (sm1),
    .serial_bit_tick_i          (tick),
    .serial_end_bit_i           (end_bit),
    .serial_start_shifter_reg_o (load_o),
    .serial_shift_o             (shift_o),
    .serial_start_bit_o         (start_o),
    .serial_stop_bit_gen_o      (stop_o),
    .serial_ti_set_o            (ti_o),
    .serial_tx_busy_o           (busy_o),
    .serial_tx_err_o            (err_o)
  );

  int n_vec = 0;
  int n_miss = 0;

  // ---------------- frame arithmetic from the mode rules ----------------
  function automatic int frame_n(input logic [1:0] md);
    return md[1] ? 9 : 8;
  endfunction
  function automatic int first_shift_tick(input logic [1:0] md);
    return (md == 2'b00) ? 2 : 3;
  endfunction
  function automatic int ti_tick(input logic [1:0] md);
    return (md == 2'b00) ? 9 : frame_n(md) + 2;
  endfunction
  function automatic int frame_ticks(input logic [1:0] md);
    return (md == 2'b00) ? 9 : frame_n(md) + 3;
  endfunction

  // ---------------- reference model: frame position by ticks seen ----------------
  logic       m_started = 1'b0;
  logic       m_active = 1'b0;
  logic       m_load = 1'b0;
  logic       m_jt = 1'b0;
  logic       m_chk = 1'b0;
  logic       m_err = 1'b0;
  logic [1:0] m_mode = 2'b00;
  int         m_k = 0;

  always @(posedge clk) begin
    logic nth_now;
    m_started = 1'b1;
    if (!rst_b) begin
      m_active = 1'b0; m_load = 1'b0; m_jt = 1'b0; m_chk = 1'b0;
      m_err = 1'b0; m_mode = 2'b00; m_k = 0;
    end else begin
      nth_now = m_active && !m_load && m_jt &&
                (m_k == first_shift_tick(m_mode) + frame_n(m_mode) - 1);
      if (m_chk && !end_bit) m_err = 1'b1;
      if (!m_active) begin
        if (wr) begin
          m_active = 1'b1; m_load = 1'b1; m_k = 0; m_jt = 1'b0;
        end
      end else begin
        if (wr) m_err = 1'b1;
        if (m_load) begin
          m_load = 1'b0;
          m_mode = {sm0, sm1};
        end else if (m_jt && (m_k == frame_ticks(m_mode))) begin
          m_active = 1'b0;
          m_jt = 1'b0;
        end else begin
          m_jt = tick;
          if (tick) m_k++;
        end
      end
      m_chk = nth_now;
    end
  end

  function automatic logic [6:0] model_outputs();
    logic ld, sh, st, sp, ti;
    int fs, n;
    fs = first_shift_tick(m_mode);
    n  = frame_n(m_mode);
    ld = m_active && m_load;
    sh = m_active && !m_load && m_jt && (m_k >= fs) && (m_k <= fs + n - 1);
    st = m_active && !m_load && (m_mode != 2'b00) && (m_k == 1);
    sp = m_active && !m_load && (m_mode != 2'b00) && (m_k == n + 2);
    ti = m_active && !m_load && m_jt && (m_k == ti_tick(m_mode));
    return {ld, sh, st, sp, ti, m_active, m_err};
  endfunction

  wire [6:0] act_vec = {load_o, shift_o, start_o, stop_o, ti_o, busy_o, err_o};

  always @(negedge clk) begin
    logic [6:0] e;
    if (m_started) begin
      e = model_outputs();
      n_vec++;
      if (act_vec !== e) begin
        n_miss++;
        $display("FAIL cycle_outputs t=%0t {load,shift,start,stop,ti,busy,err} got=%b want=%b",
                 $time, act_vec, e);
      end
    end
  end

  // ---------------- shifter stand-in: end_bit rises the cycle after the Nth shift ----------------
  int   sh_n = 8;
  logic end_ok_g = 1'b1;
  int   cur_n = 8;
  logic cur_ok = 1'b1;
  int   sh_cnt = 0;
  logic pend = 1'b0;

  always @(negedge clk) begin
    if (load_o === 1'b1) begin
      cur_n = sh_n; cur_ok = end_ok_g; sh_cnt = 0; pend = 1'b0; end_bit = 1'b0;
    end else begin
      if (pend && cur_ok) end_bit = 1'b1;
      pend = 1'b0;
      if (shift_o === 1'b1) begin
        sh_cnt++;
        if (sh_cnt == cur_n) pend = 1'b1;
      end
    end
  end

  // ---------------- drivers ----------------
  int period_g = 5;
  int tick_gap = 0;
  int ticks = 0;

  task automatic drive(input logic w);
    wr = w;
    if (tick_gap == 0) begin
      tick = 1'b1; tick_gap = period_g - 1; ticks++;
    end else begin
      tick = 1'b0; tick_gap--;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr = 1'b0; tick = 1'b0; rst_b = 1'b1;
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_miss++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  typedef struct {
    logic [1:0] md;
    int  period;
    bit  end_ok;
    int  wr_tick;
    int  rst_shifts;
    bit  pre_rst;
    int  e_loads;
    int  e_shifts;
    int  e_tis;
    int  e_ti_tk;
    int  e_st_tk;
    int  e_sp_tk;
    int  e_total;
    int  e_err;
  } frame_vec_t;

  frame_vec_t tbl[9];

  task automatic run_frame(input frame_vec_t v, input int idx);
    int loads, shifts, tis, ti_tk, st_tk, sp_tk, cyc;
    bit seen, done, rst_done;
    logic w;
    loads = 0; shifts = 0; tis = 0; ti_tk = 0; st_tk = 0; sp_tk = 0;
    seen = 1'b0; done = 1'b0; rst_done = 1'b0;
    if (v.pre_rst) begin
      @(negedge clk); rst_b = 1'b0; wr = 1'b0; tick = 1'b0;
      @(negedge clk); rst_b = 1'b1;
    end
    @(negedge clk);
    {sm0, sm1} = v.md;
    sh_n = frame_n(v.md);
    end_ok_g = v.end_ok;
    period_g = v.period;
    ticks = 0;
    tick = 1'b0;
    tick_gap = 3;
    wr = 1'b1;
    for (cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      if (load_o) loads++;
      if (shift_o) shifts++;
      if (ti_o) begin tis++; ti_tk = ticks; end
      if (start_o && st_tk == 0) st_tk = ticks;
      if (stop_o && sp_tk == 0) sp_tk = ticks;
      if (busy_o) seen = 1'b1;
      if (seen && !busy_o) begin
        done = 1'b1;
      end else begin
        rst_b = 1'b1;
        if (v.rst_shifts != 0 && shifts == v.rst_shifts && !rst_done) begin
          rst_b = 1'b0; rst_done = 1'b1;
        end
        if (busy_o && !load_o) {sm0, sm1} = 2'($urandom_range(3, 0));
        w = (v.wr_tick != 0) && (tick_gap == 0) && (ticks + 1 == v.wr_tick);
        drive(w);
      end
    end
    if (!done) chk_int($sformatf("frame%0d_timeout", idx), 0, 1);
    chk_int($sformatf("frame%0d_loads", idx), loads, v.e_loads);
    chk_int($sformatf("frame%0d_shifts", idx), shifts, v.e_shifts);
    chk_int($sformatf("frame%0d_ti_count", idx), tis, v.e_tis);
    chk_int($sformatf("frame%0d_ti_tick", idx), ti_tk, v.e_ti_tk);
    chk_int($sformatf("frame%0d_start_tick", idx), st_tk, v.e_st_tk);
    chk_int($sformatf("frame%0d_stop_tick", idx), sp_tk, v.e_sp_tk);
    chk_int($sformatf("frame%0d_total_ticks", idx), ticks, v.e_total);
    chk_int($sformatf("frame%0d_err", idx), int'(err_o), v.e_err);
    idle(3);
  endtask

  initial begin
    logic w;
    //            md  per ok wt rs pr ld sh ti titk st sp tot err
    tbl[0] = '{2'd0, 6, 1, 0, 0, 0, 1, 8, 1,  9, 0,  0,  9, 0};
    tbl[1] = '{2'd1, 5, 1, 0, 0, 0, 1, 8, 1, 10, 1, 10, 11, 0};
    tbl[2] = '{2'd3, 4, 1, 0, 0, 0, 1, 9, 1, 11, 1, 11, 12, 0};
    tbl[3] = '{2'd2, 7, 1, 0, 0, 0, 1, 9, 1, 11, 1, 11, 12, 0};
    tbl[4] = '{2'd1, 5, 0, 0, 0, 0, 1, 8, 1, 10, 1, 10, 11, 1};
    tbl[5] = '{2'd0, 4, 1, 0, 0, 0, 1, 8, 1,  9, 0,  0,  9, 1};
    tbl[6] = '{2'd1, 6, 1, 5, 0, 1, 1, 8, 1, 10, 1, 10, 11, 1};
    tbl[7] = '{2'd1, 5, 1, 0, 4, 1, 1, 4, 0,  0, 1,  0,  6, 0};
    tbl[8] = '{2'd3, 5, 1, 0, 0, 0, 1, 9, 1, 11, 1, 11, 12, 0};

    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    chk_int("reset_outputs", int'(act_vec), 0);
    rst_b = 1'b1;
    idle(2);

    for (int i = 0; i < 9; i++) run_frame(tbl[i], i);

    // Randomized traffic with occasional resets and writes while busy.
    @(negedge clk); rst_b = 1'b0;
    @(negedge clk); rst_b = 1'b1;
    tick_gap = 2;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_b = ($urandom_range(499, 0) != 0);
      w = 1'b0;
      if (!busy_o && $urandom_range(5, 0) == 0) begin
        {sm0, sm1} = 2'($urandom_range(3, 0));
        sh_n = frame_n({sm0, sm1});
        end_ok_g = ($urandom_range(7, 0) != 0);
        w = 1'b1;
      end else if (busy_o && !load_o) begin
        if ($urandom_range(3, 0) == 0) {sm0, sm1} = 2'($urandom_range(3, 0));
        if ($urandom_range(399, 0) == 0) w = 1'b1;
      end
      if (tick_gap == 0) period_g = $urandom_range(8, 4);
      drive(w);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
